bp_cacc_msg_arbiter: RTL
========================

Name: bp_cacc_msg_arbiter

Overview:
- Round-robin arbiter that shares one BedRock message channel (header + data, one beat per message) among num_src_p requesters.
- In the coherent accelerator tile it merges the I/O CCE command stream and the accelerator LCE command stream ahead of a single wormhole adapter.
- Per-source credit counters cap each requester's outstanding messages.
- A 2-entry output FIFO decouples the arbitration decision from downstream backpressure.

Parameters:
- num_src_p, 2, number of requesters (2..8).
- hdr_width_p, 64, BedRock header width in bits.
- data_width_p, 512, data payload width (cce_block_width_p).
- credits_p, 4, maximum outstanding messages per source (1..15).
- credit_width_p, $clog2(credits_p+1), credit counter width (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- src_header_i  in  num_src_p*hdr_width_p  per-source headers; source i occupies slice i.
- src_data_i  in  num_src_p*data_width_p  per-source data.
- src_v_i  in  num_src_p  per-source valid.
- src_ready_and_o  out  num_src_p  per-source ready; transfer on src_v_i[i] & src_ready_and_o[i].
- header_o  out  hdr_width_p  merged header (FIFO head).
- data_o  out  data_width_p  merged data (FIFO head).
- src_id_o  out  $clog2(num_src_p)  source index of the FIFO head.
- v_o  out  1  output valid.
- ready_and_i  in  1  downstream ready; dequeue on v_o & ready_and_i.
- credit_return_i  in  num_src_p  one pulse per completed message, per source.
- credit_err_o  out  1  sticky error: credit return received while that source's counter was already full.

Behaviour:
- Reset (async assert, sync-deasserted usage):
  - FIFO emptied; v_o=0; header_o, data_o, src_id_o = 0.
  - All credit counters = credits_p.
  - rr pointer = num_src_p-1, so source 0 has first priority.
  - credit_err_o=0; src_ready_and_o=0.
  - Reset mid-operation drops any queued messages and restores all credits.
- Eligibility: elig[i] = src_v_i[i] & (credit[i]!=0) & (fifo_count<2).
- Arbitration (combinational):
  - Grant the first eligible source scanning upward from rr+1, wrapping modulo num_src_p.
  - grant is one-hot or zero.
  - src_ready_and_o = grant; no ready is ever asserted to an ineligible or invalid source.
- Enqueue:
  - Fires when the grant is nonzero; {header, data, index} is written to the FIFO tail.
  - rr pointer updates to the granted index on the same edge.
  - rr is unchanged in cycles with no grant.
- FIFO:
  - 2 entries, no bypass: a message accepted in cycle N is visible on v_o in cycle N+1 at the earliest.
  - Full (count==2) blocks all grants, even if a dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue at count==1 keeps count at 1.
  - Outputs hold stable while v_o=1 and ready_and_i=0.
- Credits, per source:
  - Decrement on accept; increment on credit_return_i[i].
  - Both in the same cycle leave the counter unchanged.
  - Counter==0 masks eligibility; the source is restored the cycle after a return.
  - A return while the counter==credits_p (and no same-cycle accept) leaves the counter saturated and sets credit_err_o until reset.
- Width rules:
  - Counters never wrap.
  - src_id_o is zero-extended as needed.
  - When num_src_p is not a power of 2, pointer arithmetic wraps at num_src_p-1 back to 0.

Test Plan:
- Single source: src 0 valid with header 0xA5, ready_and_i=1 → src_ready_and_o[0]=1 in cycle 0; v_o=1 with header_o=0xA5, src_id_o=0 in cycle 1.
- Fairness: both sources continuously valid, ready_and_i=1, credits returned each dequeue → grant order 0,1,0,1,…; no source granted twice consecutively while the other is eligible.
- Backpressure: ready_and_i=0 → exactly 2 accepts, then src_ready_and_o=0. Raise ready_and_i → FIFO drains in acceptance order, header_o stable while stalled.
- Credit exhaustion: credits_p=4, no returns → source 1 accepted 4 times then masked while source 0 still served. One credit_return_i[1] pulse → source 1 granted again the next cycle.
- Simultaneous accept and return on source 0 at credit=2 → counter stays 2. Return on source 1 at credit=4 → credit_err_o=1 and held.
- Reset mid-operation: assert reset_i with 2 queued messages and credits at 1 → v_o=0 immediately (asynchronous). After release, all credits=credits_p and source 0 wins the first contention.

Source files
------------

// File: rtl/bp_cacc_msg_arbiter.sv
// Round-robin arbiter that merges num_src_p BedRock message streams into one channel.
// Each source has a credit counter, and a 2-entry FIFO sits between the grant and the downstream port.
module bp_cacc_msg_arbiter #(
  parameter int num_src_p      = 2,
  parameter int hdr_width_p    = 64,
  parameter int data_width_p   = 512,
  parameter int credits_p      = 4,
  parameter int credit_width_p = $clog2(credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*hdr_width_p-1:0]  src_header_i,
  input  logic [num_src_p*data_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_ready_and_o,
  output logic [hdr_width_p-1:0]            header_o,
  output logic [data_width_p-1:0]           data_o,
  output logic [$clog2(num_src_p)-1:0]      src_id_o,
  output logic                              v_o,
  input  logic                              ready_and_i,
  input  logic [num_src_p-1:0]              credit_return_i,
  output logic                              credit_err_o
);

  localparam int id_width_lp = $clog2(num_src_p);

  typedef logic [credit_width_p-1:0] credit_t;
  typedef logic [id_width_lp-1:0]    id_t;

  localparam credit_t credit_max_lp = credit_t'(credits_p);
  localparam id_t     rr_init_lp    = id_t'(num_src_p - 1);

  // Arbitration state
  id_t     rr_q, rr_d;
  credit_t credit_q [num_src_p];
  credit_t credit_d [num_src_p];
  logic    err_q, err_d;

  // FIFO storage and pointers
  logic [hdr_width_p-1:0]  hdr_mem_q  [2];
  logic [hdr_width_p-1:0]  hdr_mem_d  [2];
  logic [data_width_p-1:0] data_mem_q [2];
  logic [data_width_p-1:0] data_mem_d [2];
  id_t                     id_mem_q   [2];
  id_t                     id_mem_d   [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic [num_src_p-1:0]    elig;
  logic [num_src_p-1:0]    grant;
  logic                    grant_v;
  id_t                     grant_idx;
  logic [hdr_width_p-1:0]  sel_hdr;
  logic [data_width_p-1:0] sel_data;
  logic                    enq;
  logic                    deq;
  logic                    fifo_full;

  assign fifo_full = (count_q == 2'd2);

  // Scan upward from rr+1 and take the first eligible source; the index wraps at num_src_p-1,
  // which also covers source counts that are not a power of two.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    elig      = '0;
    grant     = '0;
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      elig[i] = src_v_i[i] && (credit_q[i] != '0) && !fifo_full && !reset_i;
    end
    for (int unsigned off = 1; off <= num_src_p; off++) begin
      idx = 32'(rr_q) + off;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (!grant_v && elig[idx]) begin
        grant_v   = 1'b1;
        grant_idx = idx[id_width_lp-1:0];
      end
    end
    if (grant_v) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_hdr  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      if (grant[i]) begin
        sel_hdr  = src_header_i[i*hdr_width_p +: hdr_width_p];
        sel_data = src_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  assign src_ready_and_o = grant;
  assign enq             = grant_v;
  assign deq             = v_o && ready_and_i;

  always_comb begin
    rr_d       = rr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hdr_mem_d  = hdr_mem_q;
    data_mem_d = data_mem_q;
    id_mem_d   = id_mem_q;
    if (enq) begin
      rr_d                 = grant_idx;
      hdr_mem_d[wr_ptr_q]  = sel_hdr;
      data_mem_d[wr_ptr_q] = sel_data;
      id_mem_d[wr_ptr_q]   = grant_idx;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // An accept and a return in the same cycle cancel out. A return at full credit stays saturated and raises the sticky error.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    for (int unsigned i = 0; i < num_src_p; i++) begin
      if (grant[i] && !credit_return_i[i]) begin
        credit_d[i] = credit_q[i] - credit_t'(1);
      end else if (credit_return_i[i] && !grant[i]) begin
        if (credit_q[i] == credit_max_lp) err_d = 1'b1;
        else credit_d[i] = credit_q[i] + credit_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q     <= rr_init_lp;
      err_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < num_src_p; i++) credit_q[i] <= credit_max_lp;
      for (int unsigned e = 0; e < 2; e++) begin
        hdr_mem_q[e]  <= '0;
        data_mem_q[e] <= '0;
        id_mem_q[e]   <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      hdr_mem_q  <= hdr_mem_d;
      data_mem_q <= data_mem_d;
      id_mem_q   <= id_mem_d;
    end
  end

  assign v_o          = (count_q != 2'd0);
  assign header_o     = hdr_mem_q[rd_ptr_q];
  assign data_o       = data_mem_q[rd_ptr_q];
  assign src_id_o     = id_mem_q[rd_ptr_q];
  assign credit_err_o = err_q;

endmodule
